// File: rtl/h_divider16_pkg.sv
// Types and helpers shared by the restoring divider and its sub-blocks.
`include "h_divider16_defs.sv"

package h_divider16_pkg;

  localparam int unsigned CNT_W = 5;
  localparam int unsigned ITERS = `H_DIV_ITERS;

  typedef enum logic [1:0] {
    ST_IDLE = `H_DIV_ST_IDLE,
    ST_RUN  = `H_DIV_ST_RUN,
    ST_DONE = `H_DIV_ST_DONE
  } state_t;

  // True on the count value that performs the final restoring step.
  function automatic logic last_step(input logic [CNT_W-1:0] cnt);
    return cnt == CNT_W'(ITERS - 1);
  endfunction

endpackage

// File: rtl/hFullAdder.sv
// One-bit full adder used as the ripple cell of the subtractor.
module hFullAdder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/hSubtractor.sv
// Ripple subtractor: a - b computed as a + ~b + 1; borrow is the inverted carry out.
module hSubtractor #(
  parameter int unsigned WIDTH = 17
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  logic [WIDTH:0] carry;

  assign carry[0] = 1'b1;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    hFullAdder u_fa (
      .a    (a[i]),
      .b    (~b[i]),
      .cin  (carry[i]),
      .sum  (diff[i]),
      .cout (carry[i+1])
    );
  end

  assign borrow = ~carry[WIDTH];

endmodule

// File: rtl/h_divider16_defs.sv
// Shared constants for the restoring divider: FSM encodings and step count.
`ifndef H_DIVIDER16_DEFS_SV
`define H_DIVIDER16_DEFS_SV

`define H_DIV_ST_IDLE 2'd0
`define H_DIV_ST_RUN  2'd1
`define H_DIV_ST_DONE 2'd2
`define H_DIV_ITERS   16

`endif

// File: rtl/h_divider16.sv
// Sequential restoring divider: one quotient bit per cycle, divide-by-zero short cut.
`include "h_divider16_defs.sv"

module h_divider16
  import h_divider16_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] divr;

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   trial;
  logic             borrow;
  logic [WIDTH:0]   rem_next;
  logic [WIDTH-1:0] q_next;
  logic             unused_rem_msb;

  // Shift {rem, q} left by one, then try subtracting the divisor at WIDTH+1 bits.
  assign rem_sh = {rem[WIDTH-1:0], q[WIDTH-1]};

  hSubtractor #(
    .WIDTH (WIDTH + 1)
  ) u_sub (
    .a      (rem_sh),
    .b      ({1'b0, divr}),
    .diff   (trial),
    .borrow (borrow)
  );

  assign rem_next = borrow ? rem_sh : trial;
  assign q_next   = {q[WIDTH-2:0], ~borrow};

  // The partial remainder never exceeds the divisor, so its top bit is always 0 here.
  assign unused_rem_msb = rem[WIDTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      rem         <= '0;
      q           <= '0;
      divr        <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          busy <= 1'b0;
          if (start) begin
            divr        <= divisor;
            div_by_zero <= 1'b0;
            busy        <= 1'b1;
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              done        <= 1'b1;
              state       <= ST_DONE;
            end else begin
              rem   <= '0;
              q     <= dividend;
              cnt   <= '0;
              state <= ST_RUN;
            end
          end
        end

        ST_RUN: begin
          rem <= rem_next;
          q   <= q_next;
          cnt <= cnt + CNT_W'(1);
          if (last_step(cnt)) begin
            quotient  <= q_next;
            remainder <= rem_next[WIDTH-1:0];
            done      <= 1'b1;
            state     <= ST_DONE;
          end
        end

        ST_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end

        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_h_divider16.sv
// Directed-vector bench for h_divider16 with hand-computed quotients and remainders.
module tb_h_divider16;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] dividend;
  logic [15:0] divisor;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        div_by_zero;

  int nvec;
  int nbad;

  h_divider16 #(.WIDTH(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Entered and left at a falling edge. Applies start for one edge, waits for done,
  // checks latency (edges after the accepting edge) and results, then one idle cycle.
  task automatic run_div(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] eq, input logic [15:0] er, input logic edz,
                         input int elat, input bit disturb);
    int n;
    bit seen;
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    @(negedge clk);
    start    = 1'b0;
    dividend = 16'($urandom);
    divisor  = 16'($urandom);
    n    = 0;
    seen = 1'b0;
    while (n <= 40) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (disturb && n >= 2) begin
        start    = 1'b1;
        dividend = 16'd1;
        divisor  = 16'd1;
      end
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    chk({tag, "_latency"}, 32'(n), 32'(elat));
    chk({tag, "_quotient"}, 32'(quotient), 32'(eq));
    chk({tag, "_remainder"}, 32'(remainder), 32'(er));
    chk({tag, "_dbz"}, 32'(div_by_zero), 32'(edz));
    chk({tag, "_busy_done"}, 32'(busy), 32'd1);
    if (disturb) begin
      start    = 1'b1;
      dividend = 16'd1;
      divisor  = 16'd1;
    end
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_done_drop"}, 32'(done), 32'd0);
    chk({tag, "_busy_idle"}, 32'(busy), 32'd0);
    chk({tag, "_q_hold"}, 32'(quotient), 32'(eq));
    chk({tag, "_r_hold"}, 32'(remainder), 32'(er));
  endtask

  initial begin
    nvec     = 0;
    nbad     = 0;
    rst_n    = 1'b0;
    start    = 1'b1;
    dividend = 16'd50;
    divisor  = 16'd5;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_quotient", 32'(quotient), 32'd0);
    chk("rst_remainder", 32'(remainder), 32'd0);
    chk("rst_dbz", 32'(div_by_zero), 32'd0);
    rst_n = 1'b1;
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);

    run_div("d100_7",     16'd100,   16'd7,     16'd14,    16'd2,     1'b0, 16, 1'b0);
    run_div("ffff_1",     16'hFFFF,  16'd1,     16'hFFFF,  16'd0,     1'b0, 16, 1'b0);
    run_div("ffff_ffff",  16'hFFFF,  16'hFFFF,  16'd1,     16'd0,     1'b0, 16, 1'b0);
    run_div("d3_8000",    16'd3,     16'h8000,  16'd0,     16'd3,     1'b0, 16, 1'b0);
    run_div("ffff_8001",  16'hFFFF,  16'h8001,  16'd1,     16'h7FFE,  1'b0, 16, 1'b0);
    run_div("d5_0",       16'd5,     16'd0,     16'hFFFF,  16'd5,     1'b1, 0,  1'b0);
    run_div("d9_3",       16'd9,     16'd3,     16'd3,     16'd0,     1'b0, 16, 1'b0);
    run_div("d200_9_dst", 16'd200,   16'd9,     16'd22,    16'd2,     1'b0, 16, 1'b1);

    // Abort 1000/3 part way through with start held high during reset.
    start    = 1'b1;
    dividend = 16'd1000;
    divisor  = 16'd3;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    chk("abort_busy_run", 32'(busy), 32'd1);
    rst_n    = 1'b0;
    start    = 1'b1;
    dividend = 16'd7;
    divisor  = 16'd7;
    @(posedge clk);
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_quotient", 32'(quotient), 32'd0);
    chk("abort_remainder", 32'(remainder), 32'd0);
    chk("abort_dbz", 32'(div_by_zero), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("abort_hold_busy", 32'(busy), 32'd0);
    chk("abort_hold_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    run_div("d1000_3", 16'd1000, 16'd3, 16'd333, 16'd1, 1'b0, 16, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule

// File: doc/h_divider16.md
H_DIVIDER16 -- requirements
Module: h_divider16

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width; all behaviour below is stated for WIDTH=16.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port start  input  1  request a division; sampled only in IDLE.
REQ-005 SHALL have port dividend  input  16  unsigned dividend; captured when start is accepted.
REQ-006 SHALL have port divisor  input  16  unsigned divisor; captured when start is accepted.
REQ-007 SHALL have port busy  output  1  high in RUN and DONE states.
REQ-008 SHALL have port done  output  1  single-cycle pulse; results valid.
REQ-009 SHALL have port quotient  output  16  result quotient.
REQ-010 SHALL have port remainder  output  16  result remainder.
REQ-011 SHALL have port div_by_zero  output  1  high with done when the captured divisor was 0.

Function
REQ-012 SHALL implement the FSM states IDLE, RUN and DONE.
REQ-013 IDLE SHALL accept start=1 at edge E0 and capture both operands.
- Divisor != 0: clear the 17-bit partial remainder, load the quotient register with the dividend, set the iteration count to 0, enter RUN.
- Divisor == 0: enter DONE directly.
REQ-014 RUN SHALL perform one restoring step per cycle.
- Shift {rem, q} left by 1.
- Compute trial = rem - divisor at 17 bits.
- No borrow: rem = trial and q[0] = 1; otherwise rem is kept and q[0] = 0.
REQ-015 RUN SHALL execute exactly 16 steps (edges E1..E16), then enter DONE.
REQ-016 done SHALL be high for exactly the one cycle spent in DONE.
- Normal case: the cycle after E16, i.e. 16 cycles after the start edge.
- Divide-by-zero case: the cycle after E0.
REQ-017 DONE SHALL return to IDLE on the next edge unconditionally.
REQ-018 start SHALL be ignored in RUN and DONE; operands SHALL NOT be re-captured and the count SHALL NOT restart.
REQ-019 quotient/remainder SHALL equal floor(dividend/divisor) and dividend mod divisor, remainder taken from rem[15:0]; rem[16] SHALL be 0 at completion.
REQ-020 Divide by zero SHALL yield quotient=16'hFFFF, remainder=captured dividend, div_by_zero=1.
REQ-021 quotient, remainder and div_by_zero SHALL hold their values from DONE until the next accepted start; div_by_zero SHALL clear on accept.
REQ-022 Operand input changes after acceptance SHALL NOT affect the result in progress.

Reset
REQ-023 rst_n=0 at a rising edge SHALL force IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, iteration count=0.
REQ-024 Reset asserted mid-RUN or in DONE SHALL abort the operation with no done pulse; start SHALL be accepted on the first edge with rst_n=1.
REQ-025 start SHALL be ignored on any edge where rst_n=0.

Structure
REQ-026 State encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the iteration count limit (16) SHALL live in a shared include header of `define constants, guarded like the other headers.
REQ-027 Subtraction SHALL be a separate sub-module, hSubtractor (parameter WIDTH).
- Built from hFullAdder as a + ~b with carry_in=1.
- Borrow = ~carry_out.
- Instantiated in the divider at WIDTH+1 bits.
REQ-028 Iteration count SHALL be a 5-bit register; no combinational path SHALL exist from start to done.

Verification
REQ-029 The bench SHALL cover 100/7 -> done 16 cycles after start, quotient=14, remainder=2, div_by_zero=0.
REQ-030 The bench SHALL cover 16'hFFFF/1 -> quotient=16'hFFFF, remainder=0; and 16'hFFFF/16'hFFFF -> quotient=1, remainder=0.
REQ-031 The bench SHALL cover 3/16'h8000 and 16'hFFFF/16'h8001 -> (0,3) and (1,16'h7FFE); this exercises the 17th remainder bit.
REQ-032 The bench SHALL cover 5/0 -> done one cycle after start, div_by_zero=1, quotient=16'hFFFF, remainder=5; a following 9/3 -> div_by_zero=0, (3,0).
REQ-033 The bench SHALL cover 200/9 with start re-pulsed and operands changed to 1/1 during RUN and in the DONE cycle -> single done, (22,2).
REQ-034 The bench SHALL cover reset pulsed at step 8 of 1000/3 -> no done pulse, all outputs 0; a subsequent 1000/3 -> (333,1).
